// File: rtl/uart_pkg.sv
// Shared UART constants and the per-cycle FIFO operation decode used by the RX buffer.
package uart_pkg;
  localparam int UART_DATA_W     = 8;
  localparam int UART_FIFO_DEPTH = 16;
  localparam int UART_TOUT_W     = 16;

  typedef struct packed {
    logic wr;    // byte accepted into the FIFO
    logic rd;    // head entry popped
    logic drop;  // byte lost to a full FIFO
  } fifo_op_t;
endpackage

// File: rtl/uart_rx_fifo_if.sv
// Bundle between the RX deserialiser / register block (master) and the RX FIFO (slave).
interface uart_rx_fifo_if #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 8,
  parameter int TOUT_W = 16
);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic [DATA_W-1:0] rx_data_i;
  logic              rx_valid_i;
  logic              clr_i;
  logic              rd_en_i;
  logic [DATA_W-1:0] rd_data_o;
  logic              empty_o;
  logic              full_o;
  logic [LVL_W-1:0]  level_o;
  logic [LVL_W-1:0]  thresh_i;
  logic              thresh_irq_o;
  logic [TOUT_W-1:0] timeout_i;
  logic              tout_irq_o;
  logic              overrun_o;
  logic              ovr_clr_i;

  modport slave (
    input  rx_data_i, rx_valid_i, clr_i, rd_en_i, thresh_i, timeout_i, ovr_clr_i,
    output rd_data_o, empty_o, full_o, level_o, thresh_irq_o, tout_irq_o, overrun_o
  );

  modport master (
    output rx_data_i, rx_valid_i, clr_i, rd_en_i, thresh_i, timeout_i, ovr_clr_i,
    input  rd_data_o, empty_o, full_o, level_o, thresh_irq_o, tout_irq_o, overrun_o
  );
endinterface

// File: rtl/uart_fifo_ram.sv
// FIFO storage: synchronous write port, asynchronous (combinational) read port.
module uart_fifo_ram #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  assign rdata = mem[raddr];
endmodule

// File: rtl/uart_rx_fifo.sv
// UART RX show-ahead FIFO with overrun, level-threshold and character-timeout interrupts.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH  = UART_FIFO_DEPTH,
  parameter int DATA_W = UART_DATA_W,
  parameter int TOUT_W = UART_TOUT_W
) (
  input  logic           clk,
  input  logic           rst,
  uart_rx_fifo_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [LVL_W-1:0]  level, level_nxt;
  logic [TOUT_W-1:0] tcnt;
  logic [DATA_W-1:0] ram_rdata;
  logic              empty, full;
  logic              thresh_irq, tout_irq, overrun;
  fifo_op_t          op;

  assign empty = (level == '0);
  assign full  = (level == LVL_W'(DEPTH));

  // A read frees a slot in the same cycle, so a full FIFO still accepts a write alongside it.
  always_comb begin
    op      = '0;
    op.rd   = bus.rd_en_i && !empty && !bus.clr_i;
    op.wr   = bus.rx_valid_i && (!full || bus.rd_en_i) && !bus.clr_i;
    op.drop = bus.rx_valid_i && full && !bus.rd_en_i && !bus.clr_i;
  end

  always_comb begin
    level_nxt = level;
    if (bus.clr_i)          level_nxt = '0;
    else if (op.wr && !op.rd) level_nxt = level + 1'b1;
    else if (op.rd && !op.wr) level_nxt = level - 1'b1;
  end

  uart_fifo_ram #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_ram (
    .clk   (clk),
    .we    (op.wr),
    .waddr (wr_ptr),
    .wdata (bus.rx_data_i),
    .raddr (rd_ptr),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      thresh_irq <= 1'b0;
    end else begin
      level      <= level_nxt;
      thresh_irq <= (bus.thresh_i != '0) && (level_nxt >= bus.thresh_i);
      if (bus.clr_i) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (op.wr) wr_ptr <= wr_ptr + 1'b1;
        if (op.rd) rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // Idle counter compares its registered value, so the flag lands one edge after cnt reaches timeout_i.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tcnt     <= '0;
      tout_irq <= 1'b0;
    end else begin
      if (bus.clr_i || op.wr || op.rd || empty) tcnt <= '0;
      else if (tcnt != '1)                      tcnt <= tcnt + 1'b1;

      if (bus.clr_i || op.rd)                          tout_irq <= 1'b0;
      else if (bus.timeout_i != '0 && tcnt == bus.timeout_i) tout_irq <= 1'b1;
    end
  end

  // Overrun survives a flush; a new drop beats a clear in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)               overrun <= 1'b0;
    else if (op.drop)      overrun <= 1'b1;
    else if (bus.ovr_clr_i) overrun <= 1'b0;
  end

  assign bus.rd_data_o    = empty ? '0 : ram_rdata;
  assign bus.empty_o      = empty;
  assign bus.full_o       = full;
  assign bus.level_o      = level;
  assign bus.thresh_irq_o = thresh_irq;
  assign bus.tout_irq_o   = tout_irq;
  assign bus.overrun_o    = overrun;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: ordering, full/overrun, threshold and timeout interrupts.
module tb_uart_rx_fifo;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  uart_rx_fifo_if #(.DEPTH(16), .DATA_W(8), .TOUT_W(16)) bus ();

  uart_rx_fifo #(.DEPTH(16), .DATA_W(8), .TOUT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    bus.rx_data_i  = b;
    bus.rx_valid_i = 1'b1;
    tick();
    bus.rx_valid_i = 1'b0;
  endtask

  task automatic pop();
    bus.rd_en_i = 1'b1;
    tick();
    bus.rd_en_i = 1'b0;
  endtask

  task automatic flush();
    bus.clr_i = 1'b1;
    tick();
    bus.clr_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst            = 1'b1;
    bus.rx_data_i  = '0;
    bus.rx_valid_i = 1'b0;
    bus.clr_i      = 1'b0;
    bus.rd_en_i    = 1'b0;
    bus.thresh_i   = '0;
    bus.timeout_i  = '0;
    bus.ovr_clr_i  = 1'b0;
    repeat (2) tick();

    chk("rst_empty",   bus.empty_o,      1);
    chk("rst_full",    bus.full_o,       0);
    chk("rst_level",   bus.level_o,      0);
    chk("rst_rdata",   bus.rd_data_o,    0);
    chk("rst_ovr",     bus.overrun_o,    0);
    chk("rst_tirq",    bus.tout_irq_o,   0);
    chk("rst_thirq",   bus.thresh_irq_o, 0);
    rst = 1'b0;
    tick();

    // 1: asynchronous reset mid-stream
    bus.thresh_i = 5'd2;
    push(8'hA1); push(8'hA2); push(8'hA3);
    chk("t1_level3",   bus.level_o,      3);
    chk("t1_thirq_on", bus.thresh_irq_o, 1);
    rst = 1'b1;
    #1;
    chk("t1_empty",    bus.empty_o,      1);
    chk("t1_level0",   bus.level_o,      0);
    chk("t1_thirq",    bus.thresh_irq_o, 0);
    chk("t1_tirq",     bus.tout_irq_o,   0);
    chk("t1_ovr",      bus.overrun_o,    0);
    tick();
    rst = 1'b0;
    bus.thresh_i = '0;
    tick();

    // 2: in-order readout
    push(8'h11);
    chk("t2_head_lat", bus.rd_data_o, 8'h11);
    chk("t2_nempty",   bus.empty_o,   0);
    push(8'h22); push(8'h33);
    chk("t2_level",    bus.level_o,   3);
    chk("t2_rd0",      bus.rd_data_o, 8'h11);
    pop();
    chk("t2_rd1",      bus.rd_data_o, 8'h22);
    pop();
    chk("t2_rd2",      bus.rd_data_o, 8'h33);
    chk("t2_nempty2",  bus.empty_o,   0);
    pop();
    chk("t2_empty",    bus.empty_o,   1);
    pop();
    chk("t2_pop_empty_level", bus.level_o, 0);

    // 3: fill to 16, 17th byte dropped
    for (int i = 0; i < 16; i++) push(8'h41 + 8'(i));
    chk("t3_full",     bus.full_o,    1);
    chk("t3_level16",  bus.level_o,   16);
    chk("t3_ovr0",     bus.overrun_o, 0);
    push(8'h51);
    chk("t3_ovr1",     bus.overrun_o, 1);
    chk("t3_level_kept", bus.level_o, 16);
    chk("t3_head",     bus.rd_data_o, 8'h41);
    bus.ovr_clr_i = 1'b1;
    tick();
    bus.ovr_clr_i = 1'b0;
    chk("t3_ovr_clr",  bus.overrun_o, 0);

    // 4: full with simultaneous read+write
    bus.rx_data_i  = 8'hAA;
    bus.rx_valid_i = 1'b1;
    bus.rd_en_i    = 1'b1;
    tick();
    bus.rx_valid_i = 1'b0;
    bus.rd_en_i    = 1'b0;
    chk("t4_level16",  bus.level_o,   16);
    chk("t4_ovr0",     bus.overrun_o, 0);
    chk("t4_head",     bus.rd_data_o, 8'h42);
    for (int i = 0; i < 15; i++) pop();
    chk("t4_level1",   bus.level_o,   1);
    chk("t4_tail",     bus.rd_data_o, 8'hAA);
    flush();
    chk("t4_clr_empty", bus.empty_o,  1);
    chk("t4_clr_level", bus.level_o,  0);
    // simultaneous read+write on empty: write wins, read ignored
    bus.rx_data_i  = 8'h5C;
    bus.rx_valid_i = 1'b1;
    bus.rd_en_i    = 1'b1;
    tick();
    bus.rx_valid_i = 1'b0;
    bus.rd_en_i    = 1'b0;
    chk("t4_empty_rw_level", bus.level_o,   1);
    chk("t4_empty_rw_data",  bus.rd_data_o, 8'h5C);
    flush();

    // 5: threshold interrupt
    bus.thresh_i = 5'd4;
    push(8'h01); push(8'h02); push(8'h03);
    chk("t5_below",    bus.thresh_irq_o, 0);
    push(8'h04);
    chk("t5_at",       bus.thresh_irq_o, 1);
    pop();
    chk("t5_drop",     bus.thresh_irq_o, 0);
    flush();
    bus.thresh_i = '0;

    // 6: character timeout; counter hits 100 after 100 idle edges, flag registers on the next
    bus.timeout_i = 16'd100;
    push(8'h77);
    repeat (100) tick();
    chk("t6_before",   bus.tout_irq_o, 0);
    tick();
    chk("t6_fire",     bus.tout_irq_o, 1);
    repeat (5) tick();
    chk("t6_sticky",   bus.tout_irq_o, 1);
    pop();
    chk("t6_pop_clr",  bus.tout_irq_o, 0);
    chk("t6_pop_empty", bus.empty_o,   1);
    push(8'h78);
    repeat (49) tick();
    flush();
    repeat (150) tick();
    chk("t6_clr_noirq", bus.tout_irq_o, 0);
    chk("t6_clr_empty", bus.empty_o,    1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
